// File: rtl/coax_rx_frame_controller.sv
// Coax receive frame sequencer: finds quiesce/start/sync framing, assembles parity-checked
// words and aborts on loss of sync, strobe timeout or a missing first sync bit.
module coax_rx_frame_controller #(
    parameter int DATA_WIDTH    = 10,
    parameter int QUIESCE_BITS  = 5,
    parameter int TIMEOUT       = 32,
    parameter int RESYNC_CYCLES = 2
) (
    input  logic                  clk_19mhz,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  sample,
    input  logic                  synchronized,
    output logic                  bit_timer_reset,
    output logic                  active,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  error,
    output logic [1:0]            error_code
);
    localparam int QW = $clog2(QUIESCE_BITS + 1);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam int RW = $clog2(RESYNC_CYCLES + 1);
    localparam logic [QW-1:0] QUIESCE_MAX  = QW'(QUIESCE_BITS);
    localparam logic [BW-1:0] BIT_LAST     = BW'(DATA_WIDTH - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RESYNC_MAX   = RW'(RESYNC_CYCLES);

    typedef enum logic [2:0] {IDLE, QUIESCE, SYNC, DATA, PARITY} state_t;

    state_t                state_q, state_d;
    logic [QW-1:0]         quiesce_q, quiesce_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  acc_q, acc_d;
    logic [TW-1:0]         timeout_q, timeout_d;
    logic [RW-1:0]         resync_q, resync_d;
    logic                  word_seen_q, word_seen_d;
    logic                  active_q, active_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  perr_q, perr_d;
    logic                  error_q, error_d;
    logic [1:0]            code_q, code_d;
    logic                  in_frame;
    logic [1:0]            abort_code;

    always_comb begin
        state_d      = state_q;
        quiesce_d    = quiesce_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        acc_d        = acc_q;
        word_seen_d  = word_seen_q;
        active_d     = active_q;
        data_d       = data_q;
        perr_d       = perr_q;
        code_d       = code_q;
        data_valid_d = 1'b0;
        error_d      = 1'b0;
        resync_d     = (resync_q != '0) ? resync_q - 1'b1 : '0;
        in_frame     = (state_q == SYNC) || (state_q == DATA) || (state_q == PARITY);
        timeout_d    = '0;
        if (in_frame && !sample)
            timeout_d = timeout_q + 1'b1;

        // Abort beats a coincident sample; the bit is simply dropped.
        abort_code = 2'd0;
        if (in_frame) begin
            if (!synchronized)
                abort_code = 2'd1;
            else if (!sample && timeout_q == TIMEOUT_LAST)
                abort_code = 2'd2;
        end

        if (abort_code != 2'd0) begin
            state_d   = IDLE;
            active_d  = 1'b0;
            error_d   = 1'b1;
            code_d    = abort_code;
            resync_d  = RESYNC_MAX;
            timeout_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    quiesce_d = '0;
                    if (synchronized && resync_q == '0)
                        state_d = QUIESCE;
                end
                QUIESCE: begin
                    if (!synchronized) begin
                        state_d = IDLE;
                    end else if (sample) begin
                        if (rx) begin
                            if (quiesce_q < QUIESCE_MAX)
                                quiesce_d = quiesce_q + 1'b1;
                        end else if (quiesce_q >= QUIESCE_MAX) begin
                            state_d     = SYNC;
                            active_d    = 1'b1;
                            word_seen_d = 1'b0;
                        end else begin
                            quiesce_d = '0;
                        end
                    end
                end
                SYNC: begin
                    if (sample) begin
                        if (rx) begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                            shreg_d   = '0;
                            acc_d     = 1'b0;
                        end else begin
                            // A 0 sync bit ends the frame; before any word it is a framing fault.
                            state_d  = IDLE;
                            active_d = 1'b0;
                            resync_d = RESYNC_MAX;
                            if (!word_seen_q) begin
                                error_d = 1'b1;
                                code_d  = 2'd3;
                            end
                        end
                    end
                end
                DATA: begin
                    if (sample) begin
                        shreg_d = {shreg_q[DATA_WIDTH-2:0], rx};
                        acc_d   = acc_q ^ rx;
                        if (bit_cnt_q == BIT_LAST)
                            state_d = PARITY;
                        else
                            bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (sample) begin
                        data_d       = shreg_q;
                        perr_d       = acc_q ^ rx;
                        data_valid_d = 1'b1;
                        word_seen_d  = 1'b1;
                        state_d      = SYNC;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_19mhz) begin
        if (reset) begin
            state_q      <= IDLE;
            quiesce_q    <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            acc_q        <= 1'b0;
            timeout_q    <= '0;
            resync_q     <= '0;
            word_seen_q  <= 1'b0;
            active_q     <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            perr_q       <= 1'b0;
            error_q      <= 1'b0;
            code_q       <= 2'd0;
        end else begin
            state_q      <= state_d;
            quiesce_q    <= quiesce_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            acc_q        <= acc_d;
            timeout_q    <= timeout_d;
            resync_q     <= resync_d;
            word_seen_q  <= word_seen_d;
            active_q     <= active_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            perr_q       <= perr_d;
            error_q      <= error_d;
            code_q       <= code_d;
        end
    end

    assign bit_timer_reset = reset | (resync_q != '0);
    assign active          = active_q;
    assign data            = data_q;
    assign data_valid      = data_valid_q;
    assign parity_error    = perr_q;
    assign error           = error_q;
    assign error_code      = code_q;
endmodule

// File: tb/tb_coax_rx_frame_controller.sv
// Bench for coax_rx_frame_controller: frame table, directed corner sequences and a
// randomized run, all scored against a bit-level behavioural model.
module tb_coax_rx_frame_controller;
    localparam int DW  = 10;
    localparam int QB  = 5;
    localparam int SPB = 4;

    logic          clk_19mhz = 1'b0;
    logic          reset, rx, sample, synchronized;
    logic          bit_timer_reset, active, data_valid, parity_error, error;
    logic [DW-1:0] data;
    logic [1:0]    error_code;

    coax_rx_frame_controller dut (
        .clk_19mhz(clk_19mhz), .reset(reset), .rx(rx), .sample(sample),
        .synchronized(synchronized), .bit_timer_reset(bit_timer_reset), .active(active),
        .data(data), .data_valid(data_valid), .parity_error(parity_error),
        .error(error), .error_code(error_code)
    );

    always #5 clk_19mhz = ~clk_19mhz;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: mode 0=idle, 1=counting quiet line, 2=inside a frame.
    // pos -1 awaits a sync bit, 0..DW-1 are data bits, DW is the parity bit.
    int          m_mode = 0, m_ones = 0, m_pos = -1, m_words = 0, m_tmo = 0, m_hold = 0, m_hprev;
    logic [DW-1:0] m_sh = '0, m_data = '0;
    logic        m_acc = 0, m_perr = 0, m_active = 0, m_dv = 0, m_err = 0;
    logic [1:0]  m_code = 0;
    int          edge_cnt = 0, last_smp_edge = 0, err_edge = 0;

    task automatic m_abort(input logic [1:0] c);
        m_err = 1; m_code = c; m_active = 0; m_hold = 2; m_mode = 0;
    endtask

    always @(posedge clk_19mhz) begin
        edge_cnt++;
        if (sample) last_smp_edge = edge_cnt;
        m_dv = 0; m_err = 0;
        if (reset) begin
            m_mode = 0; m_ones = 0; m_active = 0; m_data = '0; m_perr = 0;
            m_code = 0; m_hold = 0; m_tmo = 0;
        end else begin
            m_hprev = m_hold;
            if (m_hold > 0) m_hold--;
            if (m_mode == 0) begin
                m_ones = 0;
                if (synchronized && m_hprev == 0) m_mode = 1;
            end else if (m_mode == 1) begin
                if (!synchronized) m_mode = 0;
                else if (sample) begin
                    if (rx) m_ones = (m_ones < QB) ? m_ones + 1 : QB;
                    else if (m_ones >= QB) begin
                        m_mode = 2; m_active = 1; m_pos = -1; m_words = 0; m_tmo = 0;
                    end else m_ones = 0;
                end
            end else begin
                if (!synchronized) m_abort(2'd1);
                else if (!sample) begin
                    m_tmo++;
                    if (m_tmo >= 32) m_abort(2'd2);
                end else begin
                    m_tmo = 0;
                    if (m_pos < 0) begin
                        if (rx) begin m_pos = 0; m_sh = '0; m_acc = 0; end
                        else begin
                            if (m_words == 0) begin m_err = 1; m_code = 3; end
                            m_active = 0; m_hold = 2; m_mode = 0;
                        end
                    end else if (m_pos < DW) begin
                        m_sh = {m_sh[DW-2:0], rx}; m_acc ^= rx; m_pos++;
                    end else begin
                        m_data = m_sh; m_perr = m_acc ^ rx; m_dv = 1; m_words++; m_pos = -1;
                    end
                end
            end
        end
    end

    int          mon_dv = 0, mon_err = 0, mon_rs = 0;
    logic [DW-1:0] mon_data = '0;
    logic        mon_perr = 0;
    logic [1:0]  mon_code = 0;

    always @(negedge clk_19mhz) begin
        logic ok;
        ok = (active === m_active) && (data === m_data) && (data_valid === m_dv) &&
             (error === m_err) && (error_code === m_code) &&
             (bit_timer_reset === (reset | (m_hold > 0))) && (!m_dv || parity_error === m_perr);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL model t=%0t: got act=%b data=%h dv=%b pe=%b err=%b code=%0d btr=%b expected act=%b data=%h dv=%b pe=%b err=%b code=%0d hold=%0d",
                     $time, active, data, data_valid, parity_error, error, error_code, bit_timer_reset,
                     m_active, m_data, m_dv, m_perr, m_err, m_code, m_hold);
        end
        if (data_valid) begin mon_dv++; mon_data = data; mon_perr = parity_error; end
        if (error) begin mon_err++; mon_code = error_code; err_edge = edge_cnt; end
        if (bit_timer_reset && !reset) mon_rs++;
    end

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk_19mhz); #1; end
    endtask

    task automatic send_bit(input logic b);
        rx = b; sample = 1'b1;
        tick(1);
        sample = 1'b0; rx = 1'($urandom);
        tick(SPB - 1);
    endtask

    task automatic send_word(input logic [DW-1:0] w, input logic p);
        send_bit(1'b1);
        for (int b = DW - 1; b >= 0; b--) send_bit(w[b]);
        send_bit(p);
    endtask

    task automatic send_start(input int nq);
        repeat (nq) send_bit(1'b1);
        send_bit(1'b0);
    endtask

    typedef struct {
        int nq; int nw;
        logic [DW-1:0] w0; logic p0; logic [DW-1:0] w1; logic p1;
        int exp_dv; logic [DW-1:0] exp_data; logic exp_perr; int exp_err; logic [1:0] exp_code;
    } frame_vec_t;

    frame_vec_t tbl[6];
    int dv0, err0, rs0;

    initial begin
        // 0x2A5 and 0x155 have five 1s, so even parity needs a 1 parity bit.
        tbl[0] = '{5, 1, 10'h2A5, 1'b1, 10'h000, 1'b0, 1, 10'h2A5, 1'b0, 0, 2'd0};
        tbl[1] = '{5, 1, 10'h2A5, 1'b0, 10'h000, 1'b0, 1, 10'h2A5, 1'b1, 0, 2'd0};
        tbl[2] = '{7, 2, 10'h2A5, 1'b0, 10'h155, 1'b1, 2, 10'h155, 1'b0, 0, 2'd0};
        tbl[3] = '{5, 0, 10'h000, 1'b0, 10'h000, 1'b0, 0, 10'h000, 1'b0, 1, 2'd3};
        tbl[4] = '{6, 1, 10'h3FF, 1'b0, 10'h000, 1'b0, 1, 10'h3FF, 1'b0, 0, 2'd0};
        tbl[5] = '{5, 1, 10'h000, 1'b1, 10'h000, 1'b0, 1, 10'h000, 1'b1, 0, 2'd0};

        reset = 1'b1; rx = 1'b1; sample = 1'b0; synchronized = 1'b0;
        tick(3);
        chk("rst_bit_timer_reset", bit_timer_reset, 1);
        chk("rst_active", active, 0);
        chk("rst_data", data, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_error_code", error_code, 0);
        reset = 1'b0; synchronized = 1'b1;
        tick(4);
        chk("post_rst_bit_timer_reset", bit_timer_reset, 0);

        foreach (tbl[i]) begin
            dv0 = mon_dv; err0 = mon_err; rs0 = mon_rs;
            send_start(tbl[i].nq);
            if (tbl[i].nw > 0) send_word(tbl[i].w0, tbl[i].p0);
            if (tbl[i].nw > 1) send_word(tbl[i].w1, tbl[i].p1);
            send_bit(1'b0);
            tick(8);
            chk($sformatf("tbl%0d_dv_count", i), mon_dv - dv0, tbl[i].exp_dv);
            chk($sformatf("tbl%0d_err_count", i), mon_err - err0, tbl[i].exp_err);
            chk($sformatf("tbl%0d_resync_clks", i), mon_rs - rs0, 2);
            chk($sformatf("tbl%0d_active", i), active, 0);
            if (tbl[i].exp_dv > 0) begin
                chk($sformatf("tbl%0d_data", i), mon_data, tbl[i].exp_data);
                chk($sformatf("tbl%0d_perr", i), mon_perr, tbl[i].exp_perr);
            end
            if (tbl[i].exp_err > 0) chk($sformatf("tbl%0d_code", i), mon_code, tbl[i].exp_code);
        end

        // Short quiet run: the first 0 must not start a frame.
        dv0 = mon_dv;
        send_start(3);
        chk("short_quiesce_active", active, 0);
        send_start(5);
        chk("full_quiesce_active", active, 1);
        send_word(10'h1C3, 1'b1);
        send_bit(1'b0);
        tick(8);
        chk("short_quiesce_dv", mon_dv - dv0, 1);
        chk("short_quiesce_data", mon_data, 10'h1C3);

        // Loss of sync mid-word.
        dv0 = mon_dv; err0 = mon_err; rs0 = mon_rs;
        send_start(5);
        send_bit(1'b1);
        repeat (4) send_bit(1'($urandom));
        synchronized = 1'b0;
        tick(1);
        synchronized = 1'b1;
        tick(8);
        chk("sync_loss_err", mon_err - err0, 1);
        chk("sync_loss_code", mon_code, 1);
        chk("sync_loss_dv", mon_dv - dv0, 0);
        chk("sync_loss_resync_clks", mon_rs - rs0, 2);
        chk("sync_loss_active", active, 0);

        // Strobes stop mid-frame.
        dv0 = mon_dv; err0 = mon_err;
        send_start(5);
        send_bit(1'b1);
        repeat (3) send_bit(1'($urandom));
        tick(40);
        chk("timeout_err", mon_err - err0, 1);
        chk("timeout_code", mon_code, 2);
        chk("timeout_clocks", err_edge - last_smp_edge, 32);
        chk("timeout_dv", mon_dv - dv0, 0);
        tick(4);

        // Reset mid-word.
        err0 = mon_err;
        send_start(5);
        send_bit(1'b1);
        repeat (5) send_bit(1'($urandom));
        reset = 1'b1;
        tick(2);
        chk("midrst_bit_timer_reset", bit_timer_reset, 1);
        chk("midrst_active", active, 0);
        chk("midrst_code", error_code, 0);
        chk("midrst_data", data, 0);
        chk("midrst_err", mon_err - err0, 0);
        reset = 1'b0;
        tick(4);

        // Randomized line, strobe gaps, sync drops and rare resets.
        begin
            int gap = 0, phase = 0;
            for (int c = 0; c < 6000; c++) begin
                if (gap > 0) begin gap--; sample = 1'b0; end
                else sample = (phase == 0);
                phase = (phase + 1) % SPB;
                if ($urandom_range(0, 49) == 0) phase = $urandom_range(0, SPB - 1);
                rx = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 299) == 0) gap = 40;
                synchronized = ($urandom_range(0, 399) != 0);
                reset = ($urandom_range(0, 1499) == 0);
                tick(1);
            end
        end
        reset = 1'b0; sample = 1'b0; synchronized = 1'b1;
        tick(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
